cpu_boot_controller: RTL and testbench

Sequences one CPU run per assertion of start: holds the CPU core in reset, writes two run parameters (SP, EP) into data memory, releases the CPU, and watches for the result write. It also arbitrates the single data-memory write port between its own loader and the CPU. The block sits between the top level and the CPU/data-memory pair. It has a watchdog that aborts runs which never report a result.

---
 rtl/cpu_boot_controller_pkg.sv | 17 +
 rtl/cpu_boot_controller_if.sv | 22 ++
 rtl/cpu_boot_controller_watchdog.sv | 26 ++
 rtl/cpu_boot_controller.sv | 170 +++++++++++++++++
 tb/tb_cpu_boot_controller.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_boot_controller_pkg.sv
// rtl/cpu_boot_controller_pkg.sv - shared types and default constants for the CPU boot controller
package cpu_boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD0,
    LOAD1,
    RUN,
    DONE
  } boot_state_t;

  localparam logic [31:0] DEF_PARAM0_ADDR = 32'h0200_0000;
  localparam logic [31:0] DEF_PARAM1_ADDR = 32'h0200_0004;
  localparam logic [31:0] DEF_RESULT_ADDR = 32'h0200_0008;
  localparam int          DEF_TIMEOUT_W   = 20;

endpackage

// File: rtl/cpu_boot_controller_if.sv
// rtl/cpu_boot_controller_if.sv - CPU data port and data-memory write port bundle
interface cpu_boot_controller_if;

  logic        cpu_mem_write;
  logic [31:0] cpu_data_adr;
  logic [31:0] cpu_write_data;
  logic        mem_write;
  logic [31:0] mem_data_adr;
  logic [31:0] mem_write_data;

  // master = the boot controller (owns the memory port), slave = CPU/memory side
  modport master (
    input  cpu_mem_write, cpu_data_adr, cpu_write_data,
    output mem_write, mem_data_adr, mem_write_data
  );

  modport slave (
    output cpu_mem_write, cpu_data_adr, cpu_write_data,
    input  mem_write, mem_data_adr, mem_write_data
  );

endinterface

// File: rtl/cpu_boot_controller_watchdog.sv
// rtl/cpu_boot_controller_watchdog.sv - run watchdog; expired while the counter is all-ones
module boot_watchdog #(
  parameter int WIDTH = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign expired = &count;

endmodule

// File: rtl/cpu_boot_controller.sv
// rtl/cpu_boot_controller.sv - loads SP/EP, runs the CPU once per start, arbitrates the memory write port
// Optional: WRITE_PROTECT_EN blocks CPU writes to the parameter words during RUN.
module cpu_boot_controller
  import cpu_boot_pkg::*;
#(
  parameter logic [31:0] PARAM0_ADDR = DEF_PARAM0_ADDR,
  parameter logic [31:0] PARAM1_ADDR = DEF_PARAM1_ADDR,
  parameter logic [31:0] RESULT_ADDR = DEF_RESULT_ADDR,
  parameter int          TIMEOUT_W   = DEF_TIMEOUT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           param0,
  input  logic [31:0]           param1,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [31:0]           result,
  output logic                  prot_err,
  cpu_boot_controller_if.master bus
);

  boot_state_t state, state_next;

  logic        start_q;
  logic        start_edge;
  logic [31:0] param1_q;
  logic        ld_write;
  logic [31:0] ld_adr;
  logic [31:0] ld_data;
  logic        accept;
  logic        fin_result;
  logic        fin_timeout;
  logic        blocked;
  logic        wd_expired;

  assign start_edge = start & ~start_q;

  boot_watchdog #(.WIDTH(TIMEOUT_W)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .enable  (state == RUN),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    fin_result  = 1'b0;
    fin_timeout = 1'b0;
    blocked     = 1'b0;
    busy        = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) begin
          accept     = 1'b1;
          state_next = LOAD0;
        end
      end
      LOAD0: begin
        busy       = 1'b1;
        state_next = LOAD1;
      end
      LOAD1: begin
        busy       = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
`ifdef WRITE_PROTECT_EN
        blocked = bus.cpu_mem_write &&
                  (bus.cpu_data_adr == PARAM0_ADDR || bus.cpu_data_adr == PARAM1_ADDR);
`endif
        // A result write in the expiry cycle counts as a normal finish.
        if (bus.cpu_mem_write && bus.cpu_data_adr == RESULT_ADDR) begin
          fin_result = 1'b1;
          state_next = DONE;
        end else if (wd_expired) begin
          fin_timeout = 1'b1;
          state_next  = DONE;
        end
      end
      DONE: begin
        if (!start) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_write      = ld_write;
    bus.mem_data_adr   = ld_adr;
    bus.mem_write_data = ld_data;
    if (state == RUN) begin
      bus.mem_write      = bus.cpu_mem_write & ~blocked;
      bus.mem_data_adr   = bus.cpu_data_adr;
      bus.mem_write_data = bus.cpu_write_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q   <= 1'b0;
      param1_q  <= '0;
      ld_write  <= 1'b0;
      ld_adr    <= '0;
      ld_data   <= '0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      timeout   <= 1'b0;
      result    <= '0;
    end else begin
      start_q <= start;
      if (accept) begin
        param1_q <= param1;
        ld_write <= 1'b1;
        ld_adr   <= PARAM0_ADDR;
        ld_data  <= param0;
        done     <= 1'b0;
        timeout  <= 1'b0;
      end
      if (state == LOAD0) begin
        ld_adr  <= PARAM1_ADDR;
        ld_data <= param1_q;
      end
      if (state == LOAD1) begin
        ld_write  <= 1'b0;
        cpu_reset <= 1'b0;
      end
      if (fin_result) begin
        result    <= bus.cpu_write_data;
        done      <= 1'b1;
        cpu_reset <= 1'b1;
      end
      if (fin_timeout) begin
        timeout   <= 1'b1;
        done      <= 1'b1;
        cpu_reset <= 1'b1;
      end
    end
  end

`ifdef WRITE_PROTECT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prot_err <= 1'b0;
    end else if (accept) begin
      prot_err <= 1'b0;
    end else if (blocked) begin
      prot_err <= 1'b1;
    end
  end
`else
  assign prot_err = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_boot_controller.sv
// tb/tb_cpu_boot_controller.sv - self-checking bench for cpu_boot_controller
module tb_cpu_boot_controller;

  localparam logic [31:0] P0 = 32'h0200_0000;
  localparam logic [31:0] P1 = 32'h0200_0004;
  localparam logic [31:0] RA = 32'h0200_0008;
`ifdef WRITE_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] param0;
  logic [31:0] param1;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [31:0] result;
  logic        prot_err;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$];

  cpu_boot_controller_if bus ();

  cpu_boot_controller #(.TIMEOUT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .param0    (param0),
    .param1    (param1),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .result    (result),
    .prot_err  (prot_err),
    .bus       (bus.master)
  );

  always #5 clk = ~clk;

  // status word: {cpu_reset, busy, done, timeout, prot_err, mem_write}
  wire [5:0] st = {cpu_reset, busy, done, timeout, prot_err, bus.mem_write};

  always @(negedge clk) begin
    if (!reset && bus.mem_write) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL mem_write_unexpected got adr=%h data=%h exp none", bus.mem_data_adr, bus.mem_write_data);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({bus.mem_data_adr, bus.mem_write_data} !== e) begin
          miscompares++;
          $display("FAIL mem_write got adr=%h data=%h exp adr=%h data=%h",
                   bus.mem_data_adr, bus.mem_write_data, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [31:0] adr, input logic [31:0] data);
    bus.cpu_mem_write  = 1'b1;
    bus.cpu_data_adr   = adr;
    bus.cpu_write_data = data;
  endtask

  task automatic cpu_idle();
    bus.cpu_mem_write  = 1'b0;
    bus.cpu_data_adr   = 32'h0;
    bus.cpu_write_data = 32'h0;
  endtask

  task automatic to_idle();
    start = 1'b0;
    tick();
    tick();
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    exp_q.push_back({P0, a});
    exp_q.push_back({P1, b});
    param0 = a;
    param1 = b;
    start  = 1'b1;
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    param0 = 32'h0;
    param1 = 32'h0;
    cpu_idle();
    tick();
    tick();
    vectors++;
    if (st !== 6'b100000 || bus.mem_data_adr !== 32'h0 || bus.mem_write_data !== 32'h0 || result !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state got st=%b adr=%h data=%h res=%h exp st=100000 zeros",
               st, bus.mem_data_adr, bus.mem_write_data, result);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_normal();
    exp_q.push_back({P0, 32'h10});
    exp_q.push_back({P1, 32'h20});
    param0 = 32'h10;
    param1 = 32'h20;
    start  = 1'b1;
    tick();
    param0 = 32'hDEAD;
    param1 = 32'hBEEF;
    vectors++;
    if (st !== 6'b110001 || bus.mem_data_adr !== P0 || bus.mem_write_data !== 32'h10) begin
      miscompares++;
      $display("FAIL load0 got st=%b adr=%h data=%h exp st=110001 adr=%h data=10", st, bus.mem_data_adr, bus.mem_write_data, P0);
    end
    tick();
    vectors++;
    if (st !== 6'b110001 || bus.mem_data_adr !== P1 || bus.mem_write_data !== 32'h20) begin
      miscompares++;
      $display("FAIL load1 got st=%b adr=%h data=%h exp st=110001 adr=%h data=20", st, bus.mem_data_adr, bus.mem_write_data, P1);
    end
    tick();
    vectors++;
    if (st !== 6'b010000) begin
      miscompares++;
      $display("FAIL run_entry got st=%b exp st=010000", st);
    end
  endtask

  task automatic test_result();
    exp_q.push_back({RA, 32'hAB});
    cpu_wr(RA, 32'hAB);
    tick();
    vectors++;
    if (st !== 6'b101000 || result !== 32'hAB) begin
      miscompares++;
      $display("FAIL result got st=%b res=%h exp st=101000 res=ab", st, result);
    end
    cpu_idle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (st !== 6'b101000) begin
        miscompares++;
        $display("FAIL held_start[%0d] got st=%b exp st=101000", i, st);
      end
    end
    to_idle();
    exp_q.push_back({P0, 32'h30});
    exp_q.push_back({P1, 32'h40});
    param0 = 32'h30;
    param1 = 32'h40;
    start  = 1'b1;
    tick();
    vectors++;
    if (st !== 6'b110001) begin
      miscompares++;
      $display("FAIL restart_done_clear got st=%b exp st=110001", st);
    end
    tick();
    tick();
    exp_q.push_back({RA, 32'h1234});
    cpu_wr(RA, 32'h1234);
    tick();
    vectors++;
    if (st !== 6'b101000 || result !== 32'h1234) begin
      miscompares++;
      $display("FAIL second_result got st=%b res=%h exp st=101000 res=1234", st, result);
    end
    cpu_idle();
  endtask

  task automatic test_timeout();
    int n;
    to_idle();
    launch(32'h50, 32'h60);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    vectors++;
    if (n !== 16) begin
      miscompares++;
      $display("FAIL timeout_cycles got %0d exp 16", n);
    end
    vectors++;
    if (st !== 6'b101100 || result !== 32'h1234) begin
      miscompares++;
      $display("FAIL timeout_state got st=%b res=%h exp st=101100 res=1234", st, result);
    end
  endtask

  task automatic test_protect();
    to_idle();
    exp_q.push_back({P0, 32'hAAAA});
    exp_q.push_back({P1, 32'hBBBB});
    param0 = 32'hAAAA;
    param1 = 32'hBBBB;
    start  = 1'b1;
    tick();
    vectors++;
    if (st !== 6'b110001) begin
      miscompares++;
      $display("FAIL timeout_clear got st=%b exp st=110001", st);
    end
    tick();
    tick();
    exp_q.push_back({32'h100, 32'h9});
    cpu_wr(32'h100, 32'h9);
    tick();
    if (!PROT) exp_q.push_back({P1, 32'h55});
    cpu_wr(P1, 32'h55);
    #1;
    vectors++;
    if (bus.mem_write !== !PROT) begin
      miscompares++;
      $display("FAIL prot_block got mem_write=%b exp %b", bus.mem_write, !PROT);
    end
    tick();
    cpu_idle();
    #1;
    vectors++;
    if (st !== {4'b0100, PROT, 1'b0}) begin
      miscompares++;
      $display("FAIL prot_flag got st=%b exp st=%b", st, {4'b0100, PROT, 1'b0});
    end
    exp_q.push_back({RA, 32'h77});
    cpu_wr(RA, 32'h77);
    tick();
    vectors++;
    if (st !== {4'b1010, PROT, 1'b0} || result !== 32'h77) begin
      miscompares++;
      $display("FAIL prot_result got st=%b res=%h exp st=%b res=77", st, result, {4'b1010, PROT, 1'b0});
    end
    cpu_idle();
  endtask

  task automatic test_reset_midrun();
    to_idle();
    exp_q.push_back({P0, 32'h11});
    param0 = 32'h11;
    param1 = 32'h22;
    start  = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    start = 1'b0;
    #1;
    vectors++;
    if (st !== 6'b100000 || bus.mem_data_adr !== 32'h0 || bus.mem_write_data !== 32'h0 || result !== 32'h0) begin
      miscompares++;
      $display("FAIL async_reset got st=%b adr=%h data=%h res=%h exp st=100000 zeros",
               st, bus.mem_data_adr, bus.mem_write_data, result);
    end
    tick();
    reset = 1'b0;
    tick();
    exp_q.push_back({P0, 32'h11});
    exp_q.push_back({P1, 32'h22});
    start = 1'b1;
    tick();
    vectors++;
    if (st !== 6'b110001 || bus.mem_data_adr !== P0 || bus.mem_write_data !== 32'h11) begin
      miscompares++;
      $display("FAIL reload0 got st=%b adr=%h data=%h exp st=110001 adr=%h data=11", st, bus.mem_data_adr, bus.mem_write_data, P0);
    end
    tick();
    tick();
    vectors++;
    if (st !== 6'b010000) begin
      miscompares++;
      $display("FAIL reload_run got st=%b exp st=010000", st);
    end
    exp_q.push_back({RA, 32'hC3});
    cpu_wr(RA, 32'hC3);
    tick();
    vectors++;
    if (st !== 6'b101000 || result !== 32'hC3) begin
      miscompares++;
      $display("FAIL reload_result got st=%b res=%h exp st=101000 res=c3", st, result);
    end
    cpu_idle();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_result();
    test_back_to_back();
    test_timeout();
    test_protect();
    test_reset_midrun();
    tick();
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d pending exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
